// File: rtl/game_flow_fsm.sv
// game_flow_fsm: Pong match sequencer covering title, serve countdown, play and game-over screens with score keeping.
module game_flow_fsm #(
    parameter int WIN_SCORE        = 7,
    parameter int SERVE_FRAMES     = 60,
    parameter int OVER_LOCK_FRAMES = 90
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_press,
    input  logic       point_left,
    input  logic       point_right,
    output logic       show_title,
    output logic       show_over,
    output logic       play_en,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       winner,
    output logic [1:0] state
);
    typedef enum logic [1:0] {TITLE, SERVE, PLAY, OVER} state_t;
    state_t     state_q, state_n;
    logic [7:0] cnt_q, cnt_n;
    logic [3:0] score_l_n, score_r_n, inc_l, inc_r;
    logic       dir_n, win_n, br_n;
    logic       sync1, sync2, prev, key_rise;
    assign key_rise = sync2 & ~prev;
    assign inc_l    = score_l + 4'd1;
    assign inc_r    = score_r + 4'd1;
    assign state    = state_q;
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        score_l_n = score_l;
        score_r_n = score_r;
        dir_n     = serve_dir;
        win_n     = winner;
        br_n      = 1'b0;
        case (state_q)
            TITLE: if (key_rise) begin
                state_n   = SERVE;
                cnt_n     = 8'(SERVE_FRAMES);
                score_l_n = '0;
                score_r_n = '0;
                dir_n     = 1'b1;
                br_n      = 1'b1;
            end
            SERVE: if (frame_tick) begin
                state_n = (cnt_q == 8'd1) ? PLAY : SERVE;
                cnt_n   = cnt_q - 8'd1;
            end
            PLAY: if (point_left || point_right) begin
                score_l_n = point_left ? inc_l : score_l;
                score_r_n = point_left ? score_r : inc_r;
                if ((point_left ? inc_l : inc_r) == 4'(WIN_SCORE)) begin
                    state_n = OVER;
                    cnt_n   = 8'(OVER_LOCK_FRAMES);
                    win_n   = ~point_left;
                end else begin
                    state_n = SERVE;
                    cnt_n   = 8'(SERVE_FRAMES);
                    dir_n   = point_left;
                    br_n    = 1'b1;
                end
            end
            default: if (key_rise && cnt_q == 8'd0) begin
                state_n   = SERVE;
                cnt_n     = 8'(SERVE_FRAMES);
                score_l_n = '0;
                score_r_n = '0;
                dir_n     = 1'b1;
                br_n      = 1'b1;
            end else if (frame_tick && cnt_q != 8'd0) begin
                cnt_n = cnt_q - 8'd1;
            end
        endcase
    end
    always_ff @(posedge clk_0) begin
        if (rst) begin
            state_q    <= TITLE;
            cnt_q      <= '0;
            score_l    <= '0;
            score_r    <= '0;
            serve_dir  <= 1'b0;
            winner     <= 1'b0;
            ball_reset <= 1'b0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            show_title <= 1'b1;
            show_over  <= 1'b0;
            play_en    <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            score_l    <= score_l_n;
            score_r    <= score_r_n;
            serve_dir  <= dir_n;
            winner     <= win_n;
            ball_reset <= br_n;
            sync1      <= key_press;
            sync2      <= sync1;
            prev       <= sync2;
            show_title <= state_n == TITLE;
            show_over  <= state_n == OVER;
            play_en    <= state_n == PLAY;
        end
    end
endmodule
